// File: rtl/obi_apb_demux_bridge.sv
// OBI subordinate to multi-completer APB manager bridge with address decoding,
// one outstanding transfer, optional ACCESS-phase timeout and error response.
module obi_apb_demux_bridge #(
    parameter int unsigned NumSlaves     = 4,
    parameter logic [31:0] BaseAddr      = 32'h0000_3000,
    parameter logic [31:0] SlvSize       = 32'h100,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // OBI subordinate
    input  logic                        req_i,
    input  logic [31:0]                 addr_i,
    input  logic                        we_i,
    input  logic [3:0]                  be_i,
    input  logic [31:0]                 wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic                        err_o,
    // APB manager
    output logic [NumSlaves-1:0]        psel_o,
    output logic                        penable_o,
    output logic [31:0]                 paddr_o,
    output logic                        pwrite_o,
    output logic [31:0]                 pwdata_o,
    output logic [3:0]                  pstrb_o,
    input  logic [NumSlaves-1:0]        pready_i,
    input  logic [NumSlaves-1:0][31:0]  prdata_i,
    input  logic [NumSlaves-1:0]        pslverr_i,
    output logic                        busy_o
);

    localparam int unsigned SlvShift  = $clog2(SlvSize);
    localparam int unsigned IdxW      = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int unsigned WcW       = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit          TimeoutEn = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state_reg, state_next;

    // Latched request
    logic [31:0]     addr_reg;
    logic            we_reg;
    logic [3:0]      be_reg;
    logic [31:0]     wdata_reg;
    logic [IdxW-1:0] idx_reg;

    // Last APB transfer values, shown on the bus outside SETUP/ACCESS
    logic [31:0]     hold_addr_reg;
    logic            hold_we_reg;
    logic [31:0]     hold_wdata_reg;
    logic [3:0]      hold_strb_reg;

    logic [WcW-1:0]  wait_cnt_reg;
    logic [31:0]     rdata_reg;
    logic            err_reg;

    // Address decode; the subtraction wraps for addresses below the base,
    // so the explicit lower-bound compare is what rejects them.
    logic [31:0]     offset;
    logic [31:0]     slot;
    logic            dec_hit;
    logic [IdxW-1:0] dec_idx;

    assign offset  = addr_i - BaseAddr;
    assign slot    = offset >> SlvShift;
    assign dec_hit = (addr_i >= BaseAddr) && (slot < NumSlaves);
    assign dec_idx = slot[IdxW-1:0];

    // Selected-completer view of the APB return signals
    logic [NumSlaves-1:0] sel_vec;
    logic                 pready_sel;
    logic                 pslverr_sel;
    logic [31:0]          prdata_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NumSlaves; gi++) begin : g_sel
            assign sel_vec[gi] = (idx_reg == IdxW'(gi));
        end
    endgenerate

    assign pready_sel  = |(pready_i & sel_vec);
    assign pslverr_sel = |(pslverr_i & sel_vec);

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NumSlaves; i++) begin
            if (sel_vec[i]) begin
                prdata_sel = prdata_sel | prdata_i[i];
            end
        end
    end

    logic [3:0] strb_latched;
    assign strb_latched = we_reg ? be_reg : 4'b0000;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state and handshake outputs
    logic gnt;
    logic timeout_hit;

    always_comb begin
        state_next  = state_reg;
        gnt         = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt = req_i;
                if (req_i) begin
                    state_next = dec_hit ? SETUP : RESP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout landing on the same cycle
                if (pready_sel) begin
                    state_next = RESP;
                end else if (TimeoutEn && (wait_cnt_reg == WcW'(TimeoutCycles))) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            be_reg         <= '0;
            wdata_reg      <= '0;
            idx_reg        <= '0;
            hold_addr_reg  <= '0;
            hold_we_reg    <= 1'b0;
            hold_wdata_reg <= '0;
            hold_strb_reg  <= '0;
            wait_cnt_reg   <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        addr_reg     <= addr_i;
                        we_reg       <= we_i;
                        be_reg       <= be_i;
                        wdata_reg    <= wdata_i;
                        idx_reg      <= dec_idx;
                        wait_cnt_reg <= '0;
                        rdata_reg    <= '0;
                        err_reg      <= ~dec_hit;
                    end
                end
                SETUP: begin
                    hold_addr_reg  <= addr_reg;
                    hold_we_reg    <= we_reg;
                    hold_wdata_reg <= wdata_reg;
                    hold_strb_reg  <= strb_latched;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        rdata_reg <= we_reg ? 32'h0 : prdata_sel;
                        err_reg   <= pslverr_sel;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WcW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    logic in_setup;
    logic in_access;

    assign in_setup  = (state_reg == SETUP);
    assign in_access = (state_reg == ACCESS);

    // Gate with reset so nothing is granted while held in reset
    assign gnt_o     = gnt & rst_ni;
    assign busy_o    = (state_reg != IDLE);
    assign rvalid_o  = (state_reg == RESP);
    assign rdata_o   = rvalid_o ? rdata_reg : 32'h0;
    assign err_o     = rvalid_o & err_reg;

    assign psel_o    = (in_setup || in_access) ? sel_vec : '0;
    assign penable_o = in_access;
    assign paddr_o   = in_setup ? addr_reg     : hold_addr_reg;
    assign pwrite_o  = in_setup ? we_reg       : hold_we_reg;
    assign pwdata_o  = in_setup ? wdata_reg    : hold_wdata_reg;
    assign pstrb_o   = in_setup ? strb_latched : hold_strb_reg;

endmodule

// File: doc/obi_apb_demux_bridge.md
OBI_APB_DEMUX_BRIDGE -- requirements
Module: obi_apb_demux_bridge

Interface
REQ-001 SHALL have parameter NumSlaves, default 4: number of APB completers, range 1..16.
REQ-002 SHALL have parameter BaseAddr, default 32'h0000_3000: base address of slave region 0.
REQ-003 SHALL have parameter SlvSize, default 32'h100: bytes per slave region; power of two, at least 4.
REQ-004 SHALL have parameter TimeoutCycles, default 255: maximum ACCESS-wait cycles; 0 disables the timeout.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have OBI subordinate inputs: req_i 1, addr_i 32, we_i 1, be_i 4, wdata_i 32.
REQ-008 SHALL have OBI subordinate outputs: gnt_o 1, rvalid_o 1, rdata_o 32, err_o 1.
REQ-009 SHALL have APB manager outputs: psel_o NumSlaves, penable_o 1, paddr_o 32, pwrite_o 1, pwdata_o 32, pstrb_o 4.
REQ-010 SHALL have APB manager inputs: pready_i NumSlaves, prdata_i NumSlaves x 32, pslverr_i NumSlaves.
REQ-011 SHALL have output busy_o, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, SETUP, ACCESS, RESP.
REQ-013 SHALL support at most one outstanding OBI transaction.
REQ-014 SHALL drive gnt_o = req_i combinationally in IDLE and gnt_o = 0 in every other state.
REQ-015 SHALL, on a handshake (req_i & gnt_o), latch addr_i, we_i, be_i and wdata_i.
REQ-016 SHALL decode the slave index as (addr - BaseAddr) >> log2(SlvSize) using 32-bit unsigned arithmetic.
REQ-017 SHALL treat a request as a decode miss when addr < BaseAddr or index >= NumSlaves; this includes wrap-around of the subtraction.
REQ-018 SHALL, on a decode miss, go from IDLE to RESP with err = 1 and rdata = 0, and generate no APB activity.
REQ-019 SHALL, on a decode hit, go from IDLE to SETUP.
REQ-020 SHALL, in SETUP, drive psel_o one-hot at the decoded index and penable_o = 0.
REQ-021 SHALL, in SETUP, drive paddr_o = the latched address and pwrite_o = the latched we.
REQ-022 SHALL, in SETUP, drive pwdata_o = the latched wdata.
REQ-023 SHALL, in SETUP, drive pstrb_o = the latched be for writes and 4'b0 for reads.
REQ-024 SHALL move unconditionally from SETUP to ACCESS after one cycle.
REQ-025 SHALL, in ACCESS, hold psel_o and every address, data and control output stable, with penable_o = 1.
REQ-026 SHALL, in ACCESS, sample only the selected slave's pready, prdata and pslverr; the other slaves' inputs are ignored.
REQ-027 SHALL, in ACCESS with pready = 1, capture rdata = prdata (reads) or 0 (writes) and err = pslverr, then go to RESP.
REQ-028 SHALL count ACCESS cycles with pready = 0 in a wait counter of width $clog2(TimeoutCycles+1), cleared on entry to SETUP.
REQ-029 SHALL, with TimeoutCycles != 0, abort to RESP with err = 1 and rdata = 0 when the counter equals TimeoutCycles and pready = 0.
REQ-030 SHALL deassert psel_o and penable_o on the cycle after a timeout abort.
REQ-031 SHALL give pready = 1 precedence over the timeout when both occur in the same cycle.
REQ-032 SHALL, with TimeoutCycles = 0, wait in ACCESS indefinitely.
REQ-033 SHALL, in RESP, assert rvalid_o for exactly one cycle with the captured rdata_o and err_o, then return to IDLE.
REQ-034 SHALL drive rdata_o = 0 and err_o = 0 whenever rvalid_o = 0.
REQ-035 SHALL give a decode-hit latency of 3 cycles from handshake to rvalid_o when pready is high on the first ACCESS cycle; each wait cycle adds 1.
REQ-036 SHALL give a decode-miss latency of 1 cycle from handshake to rvalid_o.
REQ-037 SHALL drive psel_o = 0 and penable_o = 0 in IDLE and RESP; paddr_o, pwdata_o, pstrb_o and pwrite_o hold their last values.

Reset
REQ-038 SHALL, while rst_ni = 0, force the state to IDLE and clear the wait counter and all latched registers, asynchronously.
REQ-039 SHALL, while rst_ni = 0, drive all outputs to 0.
REQ-040 SHALL, on reset in any state (including mid-ACCESS), drop psel_o and penable_o immediately, produce no rvalid_o for the aborted transaction, and accept a new request on the first cycle after reset release.

Verification
REQ-041 SHALL be verified for a hit read: addr 0x3104 read, slave 1 pready = 1 with prdata 0xDEADBEEF -> psel_o = 4'b0010; rvalid_o 3 cycles after gnt with rdata_o 0xDEADBEEF, err_o 0.
REQ-042 SHALL be verified for a hit write: addr 0x3008, be 4'b0011, wdata 0x1234_5678; slave 0 holds pready low for 2 cycles -> pstrb_o 4'b0011 stable across ACCESS; rvalid_o 5 cycles after gnt, rdata_o 0.
REQ-043 SHALL be verified for decode misses: addr 0x2FFC and addr 0x3400 -> no psel_o activity; rvalid_o next cycle with err_o 1, rdata_o 0.
REQ-044 SHALL be verified for timeout: TimeoutCycles = 4, slave 2 never ready -> err_o 1 after 4 wait cycles, psel_o low on the following cycle.
REQ-045 SHALL be verified for slave error and back-to-back requests: pslverr = 1 on the first access -> err_o 1; req_i held high -> gnt_o low during SETUP, ACCESS and RESP, next gnt_o in IDLE.
REQ-046 SHALL be verified for reset mid-ACCESS: rst_ni low during ACCESS -> psel_o 0 the same cycle; no rvalid_o; a fresh read after release completes normally.
